mips_mem_loader: RTL

- Parametrised memory bank with a built-in initialisation engine for the pipelined MIPS32 core. Replaces the fixed 1024 x 32 memory, which has no load path and must be preloaded from the testbench.
- Before the core runs, a host or bootstrap master streams words into the bank, or block-fills a region with a constant.
- After loading completes, the engine releases the core through core_run.
- During run, the core gets one registered read port and one write port.

---
 rtl/mips_mem_loader.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mips_mem_loader.sv
// Memory bank for the MIPS32 core with a built-in load engine. The engine streams
// words in or block-fills a region, then releases the core through core_run.
module mips_mem_loader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic              ld_mode,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_count,
    input  logic [DATA_W-1:0] ld_fill,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err,
    output logic              core_run,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FILL   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   ptr_r;
    logic [ADDR_W:0]     remaining_r;
    logic [DATA_W-1:0]   fill_r;
    logic                ld_ready_r;
    logic                ld_busy_r;
    logic                ld_done_r;
    logic                ld_err_r;
    logic                core_run_r;
    logic [DATA_W-1:0]   rd_data_r;
    logic                accept_s;
    logic                err_set_s;
    logic                ld_we_s;
    logic [DATA_W-1:0]   ld_wdata_s;
    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    // Pointer advance wraps at DEPTH, not at the address-space size.
    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
        if ({1'b0, p} >= (DEPTH_C - ONE_C)) begin
            return '0;
        end else begin
            return p + ADDR_W'(1);
        end
    endfunction

    // Next-state logic and load-engine write requests.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        err_set_s  = 1'b0;
        ld_we_s    = 1'b0;
        ld_wdata_s = ld_data;
        case (state_r)
            IDLE: begin
                if (ld_start) begin
                    accept_s = 1'b1;
                    if (ld_count == '0) begin
                        state_s = DONE;
                    end else if (ld_mode) begin
                        state_s = FILL;
                    end else begin
                        state_s = STREAM;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                err_set_s = ld_start;
                if (ld_valid) begin
                    ld_we_s = 1'b1;
                    state_s = (remaining_r == ONE_C) ? DONE : STREAM;
                end else begin
                    state_s = STREAM;
                end
            end
            FILL: begin
                err_set_s  = ld_start;
                ld_we_s    = 1'b1;
                ld_wdata_s = fill_r;
                state_s    = (remaining_r == ONE_C) ? DONE : FILL;
            end
            DONE: begin
                err_set_s = ld_start;
                state_s   = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Single write port: the engine owns it while busy, the core otherwise.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = ptr_r;
        mem_wdata_s = ld_wdata_s;
        if (ld_we_s) begin
            mem_we_s = ({1'b0, ptr_r} < DEPTH_C);
        end else if (wr_en && !ld_busy_r) begin
            mem_we_s    = ({1'b0, wr_addr} < DEPTH_C);
            mem_waddr_s = wr_addr;
            mem_wdata_s = wr_data;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // FSM state, job registers and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            remaining_r <= '0;
            fill_r      <= '0;
            ld_ready_r  <= 1'b0;
            ld_busy_r   <= 1'b0;
            ld_done_r   <= 1'b0;
            ld_err_r    <= 1'b0;
            core_run_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            ld_ready_r <= (state_s == STREAM);
            ld_busy_r  <= (state_s == STREAM) || (state_s == FILL);
            ld_done_r  <= (state_r == DONE);
            if (accept_s) begin
                ptr_r       <= ld_base;
                remaining_r <= ld_count;
                fill_r      <= ld_fill;
                ld_err_r    <= 1'b0;
                core_run_r  <= 1'b0;
            end else begin
                if (ld_we_s) begin
                    ptr_r       <= ptr_next(ptr_r);
                    remaining_r <= remaining_r - ONE_C;
                end
                if (err_set_s) begin
                    ld_err_r <= 1'b1;
                end
                if (state_r == DONE) begin
                    core_run_r <= 1'b1;
                end
            end
        end
    end

    // Registered read port; nonblocking update gives read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= '0;
        end else if ({1'b0, rd_addr} < DEPTH_C) begin
            rd_data_r <= mem_r[rd_addr[IDX_W-1:0]];
        end else begin
            rd_data_r <= '0;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s[IDX_W-1:0]] <= mem_wdata_s;
        end
    end

    assign ld_ready = ld_ready_r;
    assign ld_busy  = ld_busy_r;
    assign ld_done  = ld_done_r;
    assign ld_err   = ld_err_r;
    assign core_run = core_run_r;
    assign rd_data  = rd_data_r;

endmodule
